// File: rtl/seg_dyn_disp.sv
// Six-digit multiplexed 7-segment driver showing an 8-bit value in decimal.
// Define LEAD_ZERO_BLANK_EN to blank leading zeros in hundreds/tens.
module seg_dyn_disp #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]  data_q;
  logic [7:0]  last_conv;
  logic [7:0]  opnd;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  bit_cnt;
  logic [3:0]  hun;
  logic [3:0]  ten;
  logic [3:0]  one;
  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic        start;
  logic        hun_blank;
  logic        ten_blank;
  logic [3:0]  dig;
  logic        blank;
  logic [7:0]  seg_nxt;

  function automatic logic [3:0] dabble(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] dec7(
    input logic [3:0] d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign start   = data_q != last_conv;
  assign bcd_adj = {dabble(bcd[11:8]),
                    dabble(bcd[7:4]),
                    dabble(bcd[3:0])};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      last_conv <= '0;
      opnd      <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      hun       <= '0;
      ten       <= '0;
      one       <= '0;
    end else begin
      data_q <= data;
      case (state)
        IDLE: begin
          if (start) begin
            opnd      <= data_q;
            last_conv <= data_q;
            bcd       <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          {bcd, opnd} <= {bcd_adj, opnd} << 1;
          bit_cnt     <= bit_cnt + 3'd1;
        end
        DONE: begin
          hun <= bcd[11:8];
          ten <= bcd[7:4];
          one <= bcd[3:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  assign hun_blank = hun == 4'd0;
  assign ten_blank = (hun == 4'd0) && (ten == 4'd0);
`else
  assign hun_blank = 1'b0;
  assign ten_blank = 1'b0;
`endif

  always_comb begin
    dig   = 4'd0;
    blank = 1'b1;
    unique case (idx)
      3'd0: begin
        dig   = one;
        blank = 1'b0;
      end
      3'd1: begin
        dig   = ten;
        blank = ten_blank;
      end
      3'd2: begin
        dig   = hun;
        blank = hun_blank;
      end
      default: ;
    endcase
    seg_nxt = blank ? 8'hFF : dec7(dig);
  end

  // sel and seg share one register stage so they always change together
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      sel <= ~(6'b1 << idx);
      seg <= seg_nxt;
    end
  end

endmodule

// File: doc/seg_dyn_disp.md
SEG_DYN_DISP -- requirements
Module: seg_dyn_disp

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 16'd49_999, giving the digit slot length in clocks minus one (1 ms at 50 MHz).
REQ-002 The block SHALL have input sys_clk, 1 bit, the system clock; all logic is on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: reset rst_n, asynchronous, active-low; clock sys_clk.
REQ-004 The block SHALL have input data, 8 bits, the unsigned ROM read data to display in decimal.
REQ-005 The block SHALL have output sel, 6 bits, registered, active-low digit select; bit 0 is the rightmost digit.
REQ-006 The block SHALL have output seg, 8 bits, registered, active-low segments ordered {dp,g,f,e,d,c,b,a}.

Function
REQ-007 The block SHALL register data every clock into data_q and hold last_conv, the last operand it converted.
REQ-008 The block SHALL run a converter FSM with states IDLE, SHIFT and DONE.
REQ-009 IDLE SHALL move to SHIFT when data_q != last_conv: load the shift operand with data_q, set last_conv <= data_q, clear the 12-bit BCD accumulator and a 3-bit bit counter.
REQ-010 SHIFT SHALL do one double-dabble step per clock, exactly 8 clocks: add 3 to each BCD nibble >= 5, then shift {bcd, operand} left by one, MSB first.
REQ-011 After the 8th step the FSM SHALL enter DONE, which latches hun/ten/one display registers from the BCD accumulator in one clock and returns to IDLE.
REQ-012 The display registers SHALL hold the new value no later than 11 clocks after data changes, and SHALL never hold a partial conversion.
REQ-013 A data change during SHIFT/DONE SHALL not disturb the running conversion; a new conversion SHALL start from IDLE because last_conv != data_q. Only the latest value is kept; intermediate values may be skipped.
REQ-014 The scan counter SHALL count 0..CNT_MAX and wrap to 0; at each wrap the 3-bit digit index SHALL increment 0..5 and wrap from 5 to 0.
REQ-015 sel SHALL equal ~(6'b1 << index); digit 0 = ones, 1 = tens, 2 = hundreds, digits 3..5 blank.
REQ-016 seg decode (active-low) SHALL be 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 blank:FF; dp (bit 7) SHALL stay 1.
REQ-017 sel and seg SHALL update on the same clock edge, one clock after the index changes, so they never show a mismatched digit/segment pair.
REQ-018 The BCD nibbles SHALL be 4 bits each (hundreds 0..2, tens 0..9, ones 0..9); input range 0..255 SHALL never overflow.

Reset
REQ-019 During reset the outputs SHALL be sel=6'h3F (all off) and seg=8'hFF.
REQ-020 During reset the internal state SHALL be: scan counter 0, index 0, FSM IDLE, data_q 0, last_conv 0, hun/ten/one 0.
REQ-021 Reset asserted mid-scan or mid-conversion SHALL force all of the above immediately, without waiting for a clock; the conversion in progress is abandoned.
REQ-022 After reset release, the first clock SHALL drive sel=6'h3E and seg of digit 0.

Configuration
REQ-023 With macro LEAD_ZERO_BLANK_EN defined, hundreds SHALL blank (FF) when 0, tens SHALL blank when hundreds and tens are both 0, and ones SHALL always show.
REQ-024 Without LEAD_ZERO_BLANK_EN, hundreds, tens and ones SHALL always show, including leading zeros.

Verification (CNT_MAX=9 in simulation)
REQ-025 Reset with data=0 -> sel=3F, seg=FF while rst_n=0; after release sel=3E, seg=C0.
REQ-026 data=200 -> within 11 clocks hun/ten/one = 2/0/0; scan shows 3E:C0, 3D:C0, 3B:A4, then 37/2F/1F:FF, then repeats.
REQ-027 data=255 -> digits 3B:A4, 3D:92, 3E:92.
REQ-028 data=7 -> with LEAD_ZERO_BLANK_EN: 3B:FF, 3D:FF, 3E:F8; without: 3B:C0, 3D:C0, 3E:F8.
REQ-029 data=100, then 101 two clocks later -> display registers go 100 then 101 with no other value; final value 101 within 22 clocks.
REQ-030 rst_n pulled low mid-slot and mid-SHIFT -> sel=3F, seg=FF with no clock edge; after release, conversion restarts and the correct value shows.
